// File: rtl/decode_cycle.sv
// Decode stage of the five-stage RV32I-subset core: main/ALU decode, immediate
// extension, 32x32 register file with write-through bypass, and the ID/EX register.
module decode_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RDW,
  input  logic [31:0] ResultW,
  input  logic        FlushE,
  output logic        RegWriteE,
  output logic        ALUSrcE,
  output logic        MemWriteE,
  output logic        ResultSrcE,
  output logic        BranchE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1_E,
  output logic [31:0] RD2_E,
  output logic [31:0] Imm_Ext_E,
  output logic [4:0]  RD_E,
  output logic [4:0]  RS1_E,
  output logic [4:0]  RS2_E,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic [4:0]  RS1_D,
  output logic [4:0]  RS2_D
);

  typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10} imm_src_t;

  typedef struct packed {
    logic        reg_write;
    logic        alu_src;
    logic        mem_write;
    logic        result_src;
    logic        branch;
    logic [2:0]  alu_control;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm_ext;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } id_ex_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        reg_write, alu_src, mem_write, result_src, branch;
  imm_src_t    imm_src;
  logic [1:0]  alu_op;
  logic [2:0]  alu_control;
  logic [31:0] imm_ext;
  logic [31:0] rd1, rd2;
  logic [31:0] rf [0:31];
  logic        wb_en;
  id_ex_t      id_ex_d, id_ex_q;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign RS1_D  = InstrD[19:15];
  assign RS2_D  = InstrD[24:20];

  always_comb begin
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    mem_write  = 1'b0;
    result_src = 1'b0;
    branch     = 1'b0;
    imm_src    = IMM_I;
    alu_op     = 2'b00;
    case (opcode)
      7'b0000011: begin reg_write = 1'b1; alu_src = 1'b1; result_src = 1'b1; end
      7'b0100011: begin alu_src = 1'b1; mem_write = 1'b1; imm_src = IMM_S; end
      7'b0110011: begin reg_write = 1'b1; alu_op = 2'b10; end
      7'b0010011: begin reg_write = 1'b1; alu_src = 1'b1; alu_op = 2'b10; end
      7'b1100011: begin branch = 1'b1; imm_src = IMM_B; alu_op = 2'b01; end
      default: ;
    endcase
  end

  // Only R-type uses bit 30 to pick sub; addi with bit 30 set stays an add.
  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control = (opcode == 7'b0110011 && InstrD[30]) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  always_comb begin
    imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
    case (imm_src)
      IMM_S:   imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   imm_ext = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      default: imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
    endcase
  end

  assign wb_en = RegWriteW && (RDW != 5'd0);

  // Entry 0 is never written, so x0 reads as zero without a special case in storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_en) begin
      rf[RDW] <= ResultW;
    end
  end

  assign rd1 = (RS1_D == 5'd0) ? '0 : (wb_en && RDW == RS1_D) ? ResultW : rf[RS1_D];
  assign rd2 = (RS2_D == 5'd0) ? '0 : (wb_en && RDW == RS2_D) ? ResultW : rf[RS2_D];

  always_comb begin
    id_ex_d = '{
      reg_write:   reg_write,
      alu_src:     alu_src,
      mem_write:   mem_write,
      result_src:  result_src,
      branch:      branch,
      alu_control: alu_control,
      rd1:         rd1,
      rd2:         rd2,
      imm_ext:     imm_ext,
      rd:          InstrD[11:7],
      rs1:         RS1_D,
      rs2:         RS2_D,
      pc:          PCD,
      pc_plus4:    PCPlus4D
    };
  end

  // A flush loads an all-zero bubble, PCs included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        id_ex_q <= '0;
    else if (FlushE) id_ex_q <= '0;
    else             id_ex_q <= id_ex_d;
  end

  assign RegWriteE   = id_ex_q.reg_write;
  assign ALUSrcE     = id_ex_q.alu_src;
  assign MemWriteE   = id_ex_q.mem_write;
  assign ResultSrcE  = id_ex_q.result_src;
  assign BranchE     = id_ex_q.branch;
  assign ALUControlE = id_ex_q.alu_control;
  assign RD1_E       = id_ex_q.rd1;
  assign RD2_E       = id_ex_q.rd2;
  assign Imm_Ext_E   = id_ex_q.imm_ext;
  assign RD_E        = id_ex_q.rd;
  assign RS1_E       = id_ex_q.rs1;
  assign RS2_E       = id_ex_q.rs2;
  assign PCE         = id_ex_q.pc;
  assign PCPlus4E    = id_ex_q.pc_plus4;

endmodule

// File: doc/decode_cycle.md
# decode_cycle

Second pipeline stage of the five-stage RV32I-subset core: decodes the instruction held in the IF/ID register and reads two operands from the 32×32 register file. It writes the register file from the writeback stage and extends the immediate. All control, operand and address fields are captured into the ID/EX pipeline register, which drives the execute stage directly. It also exports source register indices to the hazard unit and accepts its flush request.

## Interface
- No parameters. Widths are fixed: XLEN = 32, 32 architectural registers.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- InstrD  in  32  instruction from IF/ID.
- PCD  in  32  PC of InstrD.
- PCPlus4D  in  32  PCD + 4.
- RegWriteW  in  1  writeback enable.
- RDW  in  5  writeback destination.
- ResultW  in  32  writeback data.
- FlushE  in  1  hazard unit: load a bubble into ID/EX at the next edge.
- RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE  out  1 each  registered control.
- ALUControlE  out  3  registered ALU operation.
- RD1_E, RD2_E  out  32  registered operands.
- Imm_Ext_E  out  32  registered extended immediate.
- RD_E  out  5  registered destination (InstrD[11:7]).
- RS1_E, RS2_E  out  5  registered sources (InstrD[19:15], InstrD[24:20]).
- PCE, PCPlus4E  out  32  registered PCD, PCPlus4D.
- RS1_D, RS2_D  out  5  combinational InstrD[19:15] and InstrD[24:20], for load-use detection.

## Operation
Main decoder, keyed on opcode InstrD[6:0]. Fields listed are RegWrite/ALUSrc/MemWrite/ResultSrc/Branch, then ImmSrc, then ALUOp.
- 0000011 lw: 1/1/0/1/0, I, 00.
- 0100011 sw: 0/1/1/0/0, S, 00.
- 0110011 R: 1/0/0/0/0, ImmSrc don't-care (drive I), 10.
- 0010011 I-ALU: 1/1/0/0/0, I, 10.
- 1100011 beq: 0/0/0/0/1, B, 01.
- Any other opcode: all controls 0, ALUOp 00. The instruction travels as a bubble.

ALU decoder. ALUControl encoding: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- ALUOp 00 gives add; ALUOp 01 gives sub.
- ALUOp 10 decodes funct3 = InstrD[14:12]:
  - 000: sub if opcode is R-type and InstrD[30] = 1, else add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - Anything else: add.

Immediate extension, always sign-extended from InstrD[31]:
- I: {20{i31}, i[31:20]}.
- S: {20{i31}, i[31:25], i[11:7]}.
- B: {19{i31}, i31, i7, i[30:25], i[11:8], 0}.

Register file:
- x0 always reads 0; writes to x0 are ignored.
- Write occurs on the rising clk edge when RegWriteW = 1 and RDW ≠ 0.
- Reads are combinational, with write-through bypass: if RegWriteW = 1, RDW ≠ 0 and RDW equals the read index, the read returns ResultW in the same cycle.
- Reset clears all 31 writable registers to 0.

ID/EX register:
- FlushE = 0: captures all decoded values on each rising edge.
- FlushE = 1: loads all zeros at the edge. RegWrite, MemWrite and Branch are all 0, so the bubble has no architectural effect.
- Flush clears PCE and PCPlus4E too.

## Timing
- rst low, asynchronously and regardless of clk:
  - every E output goes to 0;
  - every register file entry goes to 0.
- After rst deasserts, the first rising edge captures the current decode.
- RS1_D and RS2_D are combinational and valid in the same cycle as InstrD.
- Latency: one cycle. Values decoded from InstrD in cycle n appear on the E outputs after edge n+1.
- Writeback and decode of a dependent instruction in the same cycle: the bypass supplies ResultW. No extra stall is needed for a 3-instruction-apart RAW.
- FlushE and RegWriteW in the same cycle: the register file write still happens; only ID/EX is cleared.
- Reset asserted mid-instruction: any in-flight register write is lost, and the register file reads 0 afterwards.

## Test plan
- Reset: hold rst = 0 with InstrD = 0x00500093 (addi x1, x0, 5) → all E outputs are 0. Release rst, one edge → RegWriteE = 1, ALUSrcE = 1, ALUControlE = 000, Imm_Ext_E = 5, RD_E = 1.
- Writeback and bypass: RegWriteW = 1, RDW = 2, ResultW = 0x1234 in the same cycle as InstrD = 0x002081B3 (add x3, x1, x2) → RD2_E = 0x1234 after the edge. RDW = 0 with ResultW = 0xFFFF, then read x0 → 0.
- Immediates:
  - 0xFE112E23 (sw x1, -4(x2)) → Imm_Ext_E = 0xFFFFFFFC, MemWriteE = 1, RegWriteE = 0.
  - 0xFE0008E3 (beq x0, x0, -16) → Imm_Ext_E = 0xFFFFFFF0, BranchE = 1, ALUControlE = 001.
- ALU decode:
  - 0x40208233 (sub) → ALUControlE = 001.
  - 0x0020A233 (slt) → 101.
  - 0x0020E233 (or) → 011.
  - 0x0020F233 (and) → 010.
  - 0x40008213 (addi with i30 = 1) → 000.
- Flush: FlushE = 1 during lw 0x0000A103 → the next E outputs are all 0. Deassert FlushE → the next instruction is captured normally.
- Illegal opcode 0x0000007F → all controls 0, and RD_E/RS fields are still captured.
